// File: rtl/uart_rx_deser.sv
// UART receive deserializer (clk_125 domain).
// Turns the asynchronous RXD line into one byte per frame with a one-cycle
// valid pulse, plus one-cycle framing / parity error pulses.
// Optional feature: define UART_RX_PARITY_EN to add one parity bit per frame
// (PARITY_ODD selects odd parity); otherwise frames are 8N1.
module uart_rx_deser #(
   parameter int BAUD_DIV    = 1085,
   parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD  = 1'b0
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       uart_rx_vld,
   output logic [7:0] uart_rx_data,
   output logic       frame_err,
   output logic       parity_err,
   output logic       rx_busy
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY    = 3'd3,
`endif
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic                   rxd_prev;
   logic                   rxd_fall;
   logic [CW-1:0]          baud_cnt;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift_q;
   logic                   bit_tick;
`ifdef UART_RX_PARITY_EN
   logic                   perr_pend;
   logic                   perr_q;
`endif

   assign rxd_s    = sync_q[SYNC_STAGES-1];
   assign rxd_fall = rxd_prev & ~rxd_s;
   assign bit_tick = (baud_cnt == FULL_M1);
   assign rx_busy  = (state != IDLE);

   // Metastability synchronizer for RXD plus one-cycle history for edge detect;
   // resets to the idle-high line level so reset release never looks like a start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '1;
         rxd_prev <= 1'b1;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
         rxd_prev <= rxd_s;
      end
   end

   // Data bits arrive LSB first, so shift in from the top.
   always_ff @(posedge clk) begin
      if (state == DATA && bit_tick) begin
         shift_q <= {rxd_s, shift_q[7:1]};
      end
   end

   // Frame FSM with registered pulse outputs; the START half-bit wait realigns
   // the baud counter so all later full-bit samples land mid-bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         uart_rx_vld  <= 1'b0;
         uart_rx_data <= 8'h00;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_pend    <= 1'b0;
         perr_q       <= 1'b0;
`endif
      end else begin
         uart_rx_vld <= 1'b0;
         frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
               perr_pend <= 1'b0;
`endif
               if (rxd_fall) state <= START;
            end
            START: begin
               if (baud_cnt == HALF_M1) begin
                  baud_cnt <= '0;
                  state    <= rxd_s ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  if (rxd_s != ((^shift_q) ^ PARITY_ODD)) perr_pend <= 1'b1;
                  state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  baud_cnt <= '0;
                  if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                     if (perr_pend) begin
                        perr_q <= 1'b1;
                     end else begin
                        uart_rx_data <= shift_q;
                        uart_rx_vld  <= 1'b1;
                     end
`else
                     uart_rx_data <= shift_q;
                     uart_rx_vld  <= 1'b1;
`endif
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     perr_q    <= perr_pend;
`endif
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            WAIT_IDLE: begin
               baud_cnt <= '0;
               if (rxd_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- UART receive deserializer running in the clk_125 domain.
- Converts the serial RXD line into one byte per frame, presented as a single-cycle `uart_rx_vld` pulse with `uart_rx_data`.
- Sits directly upstream of the RX ping-pong buffer and feeds its `uart_rx_vld` / `uart_rx_data` inputs.
- Also reports framing errors and (optionally) parity errors as single-cycle pulses.

Parameters:
- BAUD_DIV, 1085, clk cycles per bit (125 MHz / 115200); legal range 8..65535.
- SYNC_STAGES, 2, flip-flop stages in the RXD synchronizer; legal range 2..4.

Ports:
- clk  input  1  system clock, 125 MHz.
- rst  input  1  asynchronous, active-high reset.
- uart_rxd  input  1  serial RX line; asynchronous; idle high.
- uart_rx_vld  output  1  one-cycle pulse: valid byte on `uart_rx_data`.
- uart_rx_data  output  8  received byte; held until the next valid byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch. Tied 0 when UART_RX_PARITY_EN is undefined.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is asynchronous, active-high.
  - On reset: `uart_rx_vld`=0, `uart_rx_data`=8'h00, `frame_err`=0, `parity_err`=0, `rx_busy`=0.
  - On reset: FSM=IDLE, synchronizer flops=1, bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame; no pulse is emitted for it.
- Synchronizer: `uart_rxd` passes through SYNC_STAGES flops, giving `rxd_s`. All decisions use `rxd_s` and its previous value.
- Baud counter: width clog2(BAUD_DIV); cleared on every state entry; counts 0..BAUD_DIV-1.
- Sampling points:
  - Mid-bit sample is taken when the count reaches BAUD_DIV/2-1 (integer division). This applies to START only.
  - DATA, PARITY and STOP sample at count BAUD_DIV-1 after START's mid-point realignment, so every sample lands mid-bit.
- FSM states and transitions:
  - IDLE: on a falling edge of `rxd_s` (prev=1, now=0), go to START. Falling edges are ignored in all other states.
  - START: at the mid-bit point, if `rxd_s`=1, treat it as a glitch (false start) and return to IDLE with no output. Otherwise clear the baud counter and go to DATA.
  - DATA: sample 8 bits, LSB first, into a shift register. The 3-bit counter wraps 7→0 on the 8th sample. Then go to PARITY if the feature is enabled, else STOP.
  - PARITY: sample one bit and compare with the computed parity. A mismatch is latched as a pending error. Go to STOP.
  - STOP: sample one bit.
    - If 1 and no parity error pending: load `uart_rx_data`, pulse `uart_rx_vld` on the next clk, go to IDLE.
    - If 1 and a parity error is pending: pulse `parity_err` only (`uart_rx_vld` stays 0, `uart_rx_data` unchanged), go to IDLE.
    - If 0: pulse `frame_err` (plus `parity_err` if pending), no `uart_rx_vld`, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxd_s`=1 (break/line-low condition), then go to IDLE. A new start bit is only accepted after the line has been seen high.
- Timing:
  - Latency from the mid-point of the stop bit to `uart_rx_vld` is 1 clk.
  - Total from the start-bit falling edge on `uart_rxd` to `uart_rx_vld` is SYNC_STAGES + 9.5×BAUD_DIV (+BAUD_DIV with parity) ± 1 clk.
  - Back-to-back frames are supported: IDLE is re-entered mid-stop-bit, so a start edge arriving immediately after the stop bit is caught.
- Output rules:
  - `uart_rx_vld`, `frame_err` and `parity_err` are never high for more than 1 consecutive cycle.
  - `uart_rx_vld` and `frame_err` are mutually exclusive.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - The PARITY state is compiled in; one parity bit follows the data bits.
  - Extra parameter PARITY_ODD (default 0): 0 = even parity, 1 = odd parity.
  - `parity_err` is driven as described above.
- When undefined:
  - The PARITY state, the parity logic and PARITY_ODD are absent.
  - Frame is 8N1; DATA goes directly to STOP.
  - `parity_err` is constant 0.

Test Plan:
- BAUD_DIV=16, send 8'hA5 in 8N1 format → exactly one `uart_rx_vld` pulse with `uart_rx_data`=8'hA5, arriving 2+152 ±1 clk after the start edge; `frame_err`=0.
- Back-to-back frames 8'h00, 8'hFF, 8'h55 with no idle gap → three `uart_rx_vld` pulses with the correct bytes in order; `rx_busy` stays high between frames except for the brief IDLE cycle.
- 3-clk low glitch on an idle line → no `uart_rx_vld`, no `frame_err`; FSM returns to IDLE at the START mid-point.
- Send 8'h3C with stop bit forced to 0, hold the line low for 40 clk, then send 8'h81 → `frame_err` pulses once, no `uart_rx_vld` for 8'h3C; one `uart_rx_vld` with 8'h81 afterwards.
- With UART_RX_PARITY_EN, PARITY_ODD=0: send 8'h07 with parity bit 1 → `uart_rx_vld` with data 8'h07. Same byte with parity bit 0 → `parity_err` pulse only, no `uart_rx_vld`, `uart_rx_data` unchanged.
- Assert `rst` at the 4th data bit of 8'hC3, release it, then send 8'h5A → no pulse for the aborted frame; all outputs read 0 during reset; the next frame yields 8'h5A.
